// File: rtl/bt_uart_tx.sv
// bt_uart_tx_fifo: single-clock byte queue between the bus push side and the UART serialiser.
// Latency: a push at edge N is visible in count and at pop_dat after edge N; pop_dat is read combinationally.
// Backpressure: push_rdy is low while full and a push presented then is ignored; pop is only honoured when non-empty.
module bt_uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push_vld,
   output logic                        push_rdy,
   input  logic [WIDTH-1:0]            push_dat,
   output logic                        pop_vld,
   input  logic                        pop_rdy,
   output logic [WIDTH-1:0]            pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_fire;
   logic             pop_fire;

   assign push_rdy  = (count != CNT_W'(DEPTH));
   assign pop_vld   = (count != '0);
   assign push_fire = push_vld && push_rdy;
   assign pop_fire  = pop_rdy && pop_vld;
   assign pop_dat   = mem[rd_ptr];

   // Storage: written only on an accepted push outside reset; contents need no clearing.
   always_ff @(posedge clock) begin
      if (!reset && push_fire) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_fire, pop_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// bt_uart_tx: 8N1 UART transmitter for the Bluetooth link, fed from a byte FIFO and gated by active-low CTS.
// Latency: a byte pushed at edge N can pop at edge N+1; BT_TX falls after the pop; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: tx_ready low while the FIFO is full; BT_CTS high holds new frames at IDLE but never cuts one short.
module bt_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [7:0]                       tx_data,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   input  logic                             BT_CTS,
   output logic                             BT_TX,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              bt_tx_q;
   logic              cts_meta;
   logic              cts_n;
   logic              fifo_vld;
   logic [7:0]        fifo_dat;
   logic              pop;
   logic              bit_end;

   // A new frame may start only from IDLE, with data queued and the synchronised CTS asserted (low).
   assign pop     = (state == ST_IDLE) && fifo_vld && !cts_n;
   assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   assign BT_TX = bt_tx_q;
   assign busy  = (state != ST_IDLE) || (fifo_count != '0);

   bt_uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (tx_valid),
      .push_rdy (tx_ready),
      .push_dat (tx_data),
      .pop_vld  (fifo_vld),
      .pop_rdy  (pop),
      .pop_dat  (fifo_dat),
      .count    (fifo_count)
   );

   // Two-flop synchroniser for the asynchronous CTS line; resets to "not clear".
   always_ff @(posedge clock) begin
      if (reset) begin
         cts_meta <= 1'b1;
         cts_n    <= 1'b1;
      end else begin
         cts_meta <= BT_CTS;
         cts_n    <= cts_meta;
      end
   end

   // Frame sequencer: start bit, 8 data bits LSB first, stop bit; BT_TX is driven from a flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         bt_tx_q  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               bt_tx_q  <= 1'b1;
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (pop) begin
                  shift   <= fifo_dat;
                  bt_tx_q <= 1'b0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  bt_tx_q  <= shift[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     bt_tx_q <= 1'b1;
                     state   <= ST_STOP;
                  end else begin
                     // Next bit is already sitting one place up in the shift register.
                     bt_tx_q <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_STOP: begin
               bt_tx_q <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               bt_tx_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
